// File: rtl/pico_wb_bridge.sv
// Bridge from the picorv32 native memory bus to a Wishbone B4 classic single-access master.
// Define WB_TIMEOUT_EN to abort Wishbone cycles that see no ack/err within TIMEOUT_CYCLES.
module pico_wb_bridge #(
  parameter logic [31:0] BASE_ADDR      = 32'h0300_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFF00_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clock_main,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        hit,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        err_irq,
  output logic [1:0]  err_status,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    WB_REQ,
    RESP
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t state;
  logic   in_req;
  logic   bus_err;
  logic   timeout;
  logic   fail;

  assign hit     = mem_valid && ((mem_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
  assign in_req  = (state == WB_REQ);
  // ack outranks err, and err outranks the timeout
  assign bus_err = in_req && !wbm_ack_i && wbm_err_i;
  assign fail    = bus_err || timeout;

`ifdef WB_TIMEOUT_EN
  logic [15:0] tmo_count;

  assign timeout = in_req && !wbm_ack_i && !wbm_err_i && ((tmo_count + 16'd1) == TMO_LIMIT);
`else
  logic unused_tmo;

  assign timeout    = 1'b0;
  assign unused_tmo = ^TMO_LIMIT;
`endif

  always_ff @(posedge clock_main) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= '0;
      wbm_stb_o  <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      err_irq    <= 1'b0;
      err_status <= '0;
      err_addr   <= '0;
`ifdef WB_TIMEOUT_EN
      tmo_count  <= '0;
`endif
    end else begin
      mem_ready <= 1'b0;
      err_irq   <= 1'b0;
      // a clear and a new error on the same edge leave the new flag set
      if (err_clr) begin
        err_status <= 2'b00;
      end
`ifdef WB_TIMEOUT_EN
      tmo_count <= in_req ? tmo_count + 16'd1 : 16'd0;
`endif

      case (state)
        IDLE: begin
          if (hit) begin
            wbm_adr_o <= mem_addr;
            wbm_dat_o <= mem_wdata;
            wbm_we_o  <= |mem_wstrb;
            wbm_sel_o <= (|mem_wstrb) ? mem_wstrb : 4'hF;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            state     <= WB_REQ;
          end else begin
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
          end
        end

        WB_REQ: begin
          if (wbm_ack_i) begin
            mem_rdata <= wbm_we_o ? 32'h0 : wbm_dat_i;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            mem_ready <= 1'b1;
            state     <= RESP;
          end else if (fail) begin
            mem_rdata <= wbm_we_o ? 32'h0 : ERR_DATA;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            mem_ready <= 1'b1;
            err_irq   <= 1'b1;
            err_addr  <= wbm_adr_o;
            if (bus_err) begin
              err_status[0] <= 1'b1;
            end else begin
              err_status[1] <= 1'b1;
            end
            state <= RESP;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pico_wb_bridge.md
Name: pico_wb_bridge

Overview:
Parametrised bridge from the picorv32 native memory bus to a Wishbone B4 classic single-access master. It claims one address window, selected by a base and mask. It runs one Wishbone cycle per CPU access and returns the read data and the ready handshake to the CPU's bus mux. It adds bus-error handling, an optional timeout, error status, and an error IRQ pulse. It replaces the inline iomem-to-Wishbone FSM in the SoC top level.

Parameters:
BASE_ADDR, 32'h0300_0000, window base; only bits set in ADDR_MASK are compared.
ADDR_MASK, 32'hFF00_0000, decode mask; hit = (mem_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK).
TIMEOUT_CYCLES, 255, cycles in WB_REQ without ack/err before abort (1..65535; used only with WB_TIMEOUT_EN).
ERR_DATA, 32'hDEAD_BEEF, value returned on mem_rdata for an errored or timed-out read.

Ports:
clock_main  in  1  system clock
rst_n  in  1  synchronous active-low reset
mem_valid  in  1  CPU access request
mem_addr  in  32  CPU byte address
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  byte strobes; 0 = read
hit  out  1  combinational window decode, qualified by mem_valid
mem_ready  out  1  one-cycle ready pulse to the CPU mux
mem_rdata  out  32  read data, valid while mem_ready=1
wbm_adr_o  out  32  Wishbone address
wbm_dat_o  out  32  write data
wbm_dat_i  in  32  read data
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte select
wbm_stb_o  out  1  strobe
wbm_cyc_o  out  1  cycle
wbm_ack_i  in  1  acknowledge
wbm_err_i  in  1  bus error
err_irq  out  1  one-cycle pulse on each error or timeout
err_status  out  2  sticky flags: [0] bus error seen, [1] timeout seen
err_addr  out  32  address of the most recent failed access
err_clr  in  1  clears err_status (err_addr is not cleared)

Behaviour:
- Reset is synchronous (rst_n low at a clock_main edge). All outputs go to 0, state goes to IDLE, and the timeout counter clears.
- Reset mid-cycle: cyc and stb drop on that edge. No mem_ready is issued.
- FSM has states IDLE, WB_REQ and RESP.
- IDLE: when hit=1, latch adr=mem_addr, dat=mem_wdata, we=|mem_wstrb, and sel = mem_wstrb for writes or 4'hF for reads. Assert cyc=stb=1 and go to WB_REQ. When hit=0, keep all Wishbone outputs low.
- WB_REQ: the master holds all outputs stable; the timeout counter increments each cycle. Events are handled in priority order: rst_n, then ack, then err, then timeout.
  - On ack: capture wbm_dat_i (reads only) into mem_rdata, drop cyc/stb/we, go to RESP.
  - On err (without ack): set mem_rdata=ERR_DATA, set err_status[0], set err_addr=adr, pulse err_irq, go to RESP.
  - If ack and err are high together, ack wins and no error is recorded.
- RESP: mem_ready=1 for exactly one cycle, then IDLE. mem_rdata holds its value until the next RESP; it reads as 0 for writes.
- The CPU drops mem_valid on the edge that samples mem_ready, so IDLE never restarts the same access.
- Minimum latency: mem_valid at cycle 0 → cyc/stb high from cycle 1. A slave acking in cycle 1 gives mem_ready in cycle 2. In general, ack sampled at cycle k gives mem_ready at cycle k+1.
- Back-to-back accesses: at least one IDLE cycle separates consecutive cycles, so cyc is low for at least 2 cycles between them (RESP and IDLE).
- err_clr clears err_status on the next edge. If a new error is set on the same edge, the set wins.
- mem_wstrb changing while in WB_REQ has no effect, because all request fields are latched in IDLE.

Optional Feature:
Macro WB_TIMEOUT_EN.
- Defined: while in WB_REQ, a 16-bit counter counts cycles and clears on entry to WB_REQ. When it reaches TIMEOUT_CYCLES with no ack or err, the bridge drops cyc/stb, sets mem_rdata=ERR_DATA, sets err_status[1], sets err_addr, pulses err_irq, and goes to RESP.
- Not defined: the counter logic is absent, the bridge waits indefinitely for ack or err, and err_status[1] is tied to 0.

Test Plan:
1. Read 0x0300_0010; the slave returns 0x1234_5678 with ack 3 cycles after stb → wbm_sel_o=4'hF, wbm_we_o=0, mem_ready pulses once with mem_rdata=0x1234_5678, one cycle after ack.
2. Write 0xAABB_CCDD to 0x0300_0004 with mem_wstrb=4'b0100 → wbm_we_o=1, wbm_sel_o=4'b0100, wbm_dat_o=0xAABB_CCDD; mem_ready comes 1 cycle after ack with mem_rdata=0.
3. Access to 0x0200_4000 → hit=0; cyc, stb and mem_ready stay 0 for 20 cycles.
4. Read 0x0300_0020 where the slave asserts err → mem_rdata=0xDEAD_BEEF, err_status=2'b01, err_addr=0x0300_0020, one err_irq pulse; pulsing err_clr then gives err_status=0.
5. With WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never responds → cyc drops after 8 WB_REQ cycles, err_status[1]=1, mem_rdata=0xDEAD_BEEF; without the macro, cyc stays high for 100 cycles.
6. Assert rst_n low during WB_REQ, then assert ack on the following cycle → cyc/stb are 0 one edge later, no mem_ready pulse occurs, and a subsequent read completes normally.
